// File: rtl/nes_input_pkg.sv
// nes_input_pkg
//   Shared constants for the NES player-1 controller path:
//   - USB HID keycodes that drive each NES button
//   - bit positions of each button in the {Right,Left,Down,Up,Start,Select,B,A} vector
//   - CPU addresses of the two controller ports
//   - key_to_buttons(): keycode -> button vector lookup (at most one button per key)
package nes_input_pkg;

    // USB HID keycodes
    localparam logic [7:0] KC_A      = 8'h0E;  // 'K'
    localparam logic [7:0] KC_B      = 8'h0D;  // 'J'
    localparam logic [7:0] KC_SELECT = 8'h2C;  // Space
    localparam logic [7:0] KC_START  = 8'h28;  // Enter
    localparam logic [7:0] KC_UP     = 8'h1A;  // 'W'
    localparam logic [7:0] KC_DOWN   = 8'h16;  // 'S'
    localparam logic [7:0] KC_LEFT   = 8'h04;  // 'A'
    localparam logic [7:0] KC_RIGHT  = 8'h07;  // 'D'

    // Button bit positions, in the order the NES shifts them out (A first)
    localparam int unsigned BTN_A      = 0;
    localparam int unsigned BTN_B      = 1;
    localparam int unsigned BTN_SELECT = 2;
    localparam int unsigned BTN_START  = 3;
    localparam int unsigned BTN_UP     = 4;
    localparam int unsigned BTN_DOWN   = 5;
    localparam int unsigned BTN_LEFT   = 6;
    localparam int unsigned BTN_RIGHT  = 7;

    // Controller port addresses on the CPU bus
    localparam logic [15:0] JOY1_ADDR = 16'h4016;
    localparam logic [15:0] JOY2_ADDR = 16'h4017;

    // Unknown keycodes (including 8'h00 = no key) press nothing.
    function automatic logic [7:0] key_to_buttons(input logic [7:0] kc);
        logic [7:0] btn;
        btn = '0;
        case (kc)
            KC_A:      btn[BTN_A]      = 1'b1;
            KC_B:      btn[BTN_B]      = 1'b1;
            KC_SELECT: btn[BTN_SELECT] = 1'b1;
            KC_START:  btn[BTN_START]  = 1'b1;
            KC_UP:     btn[BTN_UP]     = 1'b1;
            KC_DOWN:   btn[BTN_DOWN]   = 1'b1;
            KC_LEFT:   btn[BTN_LEFT]   = 1'b1;
            KC_RIGHT:  btn[BTN_RIGHT]  = 1'b1;
            default:   btn             = '0;
        endcase
        return btn;
    endfunction

endpackage

// File: rtl/keycode_debouncer.sv
// keycode_debouncer
//   Filters the raw USB keycode and publishes a stable NES button vector.
//   The keycode must be sampled unchanged on DEBOUNCE_CYCLES consecutive clocks
//   after the clock that first captured it before the button vector follows.
//
// Ports
//   clk_i      system clock
//   rst_ni     asynchronous active-low reset
//   keycode_i  raw USB keycode (8'h00 = no key)
//   buttons_o  debounced {Right,Left,Down,Up,Start,Select,B,A}
module keycode_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [7:0] keycode_i,
    output logic [7:0] buttons_o
);
    import nes_input_pkg::*;

    localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    logic [7:0]      last_kc_q, last_kc_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [7:0]      buttons_q, buttons_d;

    always_comb begin
        last_kc_d = last_kc_q;
        cnt_d     = cnt_q;
        buttons_d = buttons_q;
        if (keycode_i != last_kc_q) begin
            last_kc_d = keycode_i;
            cnt_d     = '0;
        end else if (cnt_q == CntMax) begin
            // Counter parks here; the vector is rewritten with the same value each cycle.
            buttons_d = key_to_buttons(last_kc_q);
        end else begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_kc_q <= '0;
            cnt_q     <= '0;
            buttons_q <= '0;
        end else begin
            last_kc_q <= last_kc_d;
            cnt_q     <= cnt_d;
            buttons_q <= buttons_d;
        end
    end

    assign buttons_o = buttons_q;

endmodule

// File: rtl/nes_controller_port.sv
// nes_controller_port
//   Player-1 NES controller responder. A debounced USB keycode becomes the
//   8-button vector, which is served to the CPU through the $4016 strobe /
//   serial-shift protocol. $4017 (player 2) reads back as no buttons pressed.
//
// Ports
//   Clk             system clock
//   Reset_n         asynchronous active-low reset
//   cpu_ce          CPU cycle enable, qualifies cpu_rd / cpu_wr
//   cpu_addr        CPU address bus
//   cpu_rd, cpu_wr  single-cycle read / write requests
//   cpu_din         CPU write data (bit 0 is the strobe)
//   cpu_dout        registered controller read data
//   cpu_dout_valid  cpu_dout holds a controller read result
//   keycode         USB keycode from the SoC PIO
//   buttons         debounced button vector, for debug LEDs
module nes_controller_port #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter logic [2:0]  OPEN_BUS        = 3'b010
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        cpu_ce,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    input  logic [7:0]  cpu_din,
    output logic [7:0]  cpu_dout,
    output logic        cpu_dout_valid,
    input  logic [7:0]  keycode,
    output logic [7:0]  buttons
);
    import nes_input_pkg::*;

    logic       strobe_q, strobe_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] dout_q, dout_d;
    logic       valid_q, valid_d;

    logic rd_req, joy1_rd, joy2_rd, joy1_wr;

    // Only the strobe bit of the write data is meaningful here.
    logic unused_din;
    assign unused_din = ^cpu_din[7:1];

    keycode_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clk_i    (Clk),
        .rst_ni   (Reset_n),
        .keycode_i(keycode),
        .buttons_o(buttons)
    );

    assign rd_req  = cpu_ce & cpu_rd;
    assign joy1_rd = rd_req & (cpu_addr == JOY1_ADDR);
    assign joy2_rd = rd_req & (cpu_addr == JOY2_ADDR);
    // $4017 writes belong to the APU frame counter and are not decoded here.
    assign joy1_wr = cpu_ce & cpu_wr & (cpu_addr == JOY1_ADDR);

    always_comb begin
        strobe_d = strobe_q;
        shift_d  = shift_q;
        dout_d   = dout_q;
        valid_d  = valid_q;

        if (joy1_wr) begin
            strobe_d = cpu_din[0];
        end

        // A high strobe reloads every cycle; this includes the write cycle
        // that drops it, which becomes the final capture. A same-cycle write
        // suppresses the shift so the read sees the pre-write bit.
        if (strobe_q) begin
            shift_d = buttons;
        end else if (joy1_rd && !joy1_wr) begin
            shift_d = {1'b1, shift_q[7:1]};
        end

        if (joy1_rd) begin
            dout_d  = {OPEN_BUS, 4'b0000, shift_q[0]};
            valid_d = 1'b1;
        end else if (joy2_rd) begin
            dout_d  = {OPEN_BUS, 5'b00000};
            valid_d = 1'b1;
        end else if (rd_req) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            strobe_q <= 1'b0;
            shift_q  <= '0;
            dout_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            strobe_q <= strobe_d;
            shift_q  <= shift_d;
            dout_q   <= dout_d;
            valid_q  <= valid_d;
        end
    end

    assign cpu_dout       = dout_q;
    assign cpu_dout_valid = valid_q;

endmodule

// File: tb/tb_nes_controller_port.sv
module tb_nes_controller_port;

    localparam int unsigned DC = 16;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        cpu_ce;
    logic [15:0] cpu_addr;
    logic        cpu_rd;
    logic        cpu_wr;
    logic [7:0]  cpu_din;
    logic [7:0]  cpu_dout;
    logic        cpu_dout_valid;
    logic [7:0]  keycode;
    logic [7:0]  buttons;

    always #5 Clk = ~Clk;

    nes_controller_port dut (
        .Clk           (Clk),
        .Reset_n       (Reset_n),
        .cpu_ce        (cpu_ce),
        .cpu_addr      (cpu_addr),
        .cpu_rd        (cpu_rd),
        .cpu_wr        (cpu_wr),
        .cpu_din       (cpu_din),
        .cpu_dout      (cpu_dout),
        .cpu_dout_valid(cpu_dout_valid),
        .keycode       (keycode),
        .buttons       (buttons)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    logic [7:0] m_hist[$];   // keycode samples, oldest first (reset value at the front)
    logic [7:0] m_buttons;
    logic [7:0] m_lag;       // button vector as it was one clock earlier
    bit         m_strobe;
    bit         m_bits[$];   // controller bits still to be shifted out, A first
    logic [7:0] m_dout;
    bit         m_valid;

    logic [7:0] key_pool [10] = '{8'h0E, 8'h0D, 8'h2C, 8'h28, 8'h1A,
                                  8'h16, 8'h04, 8'h07, 8'h00, 8'h55};

    function automatic logic [7:0] ref_map(input logic [7:0] kc);
        logic [7:0] codes [8];
        logic [7:0] r;
        codes = '{8'h0E, 8'h0D, 8'h2C, 8'h28, 8'h1A, 8'h16, 8'h04, 8'h07};
        r = '0;
        for (int i = 0; i < 8; i++) if (codes[i] == kc) r[i] = 1'b1;
        return r;
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_hist.delete();
        m_hist.push_back(8'h00);
        m_buttons = '0;
        m_lag     = '0;
        m_strobe  = 1'b0;
        m_bits.delete();
        repeat (8) m_bits.push_back(1'b0);
        m_dout    = '0;
        m_valid   = 1'b0;
    endtask

    // Advance the model across one rising edge using the inputs now applied.
    task automatic model_edge();
        bit wr, rd, rd1, rd2, val, all_eq;
        wr  = cpu_ce && cpu_wr && (cpu_addr == 16'h4016);
        rd  = cpu_ce && cpu_rd;
        rd1 = rd && (cpu_addr == 16'h4016);
        rd2 = rd && (cpu_addr == 16'h4017);
        // While strobe is high the port follows the live A button (one clock old).
        if (m_strobe) val = m_lag[0];
        else          val = (m_bits.size() > 0) ? m_bits[0] : 1'b1;
        if (rd1) begin
            m_dout  = {3'b010, 4'b0000, val};
            m_valid = 1'b1;
            if (!m_strobe && !wr && m_bits.size() > 0) void'(m_bits.pop_front());
        end else if (rd2) begin
            m_dout  = 8'h40;
            m_valid = 1'b1;
        end else if (rd) begin
            m_valid = 1'b0;
        end
        if (wr) begin
            if (m_strobe && !cpu_din[0]) begin
                m_bits.delete();
                for (int i = 0; i < 8; i++) m_bits.push_back(m_buttons[i]);
            end
            m_strobe = cpu_din[0];
        end
        m_lag = m_buttons;
        // Buttons follow a keycode once the last DC+1 samples all agree.
        m_hist.push_back(keycode);
        if (m_hist.size() > DC + 1) void'(m_hist.pop_front());
        if (m_hist.size() == DC + 1) begin
            all_eq = 1'b1;
            foreach (m_hist[i]) if (m_hist[i] != m_hist[0]) all_eq = 1'b0;
            if (all_eq) m_buttons = ref_map(m_hist[0]);
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge Clk);
        #1;
        check("buttons", buttons, m_buttons);
        check("valid", {7'b0, cpu_dout_valid}, {7'b0, m_valid});
        if (m_valid) check("dout", cpu_dout, m_dout);
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    // One bus cycle followed by one quiet cycle.
    task automatic bus(input bit ce, input bit rd, input bit wr,
                       input logic [15:0] a, input logic [7:0] d);
        cpu_ce = ce; cpu_rd = rd; cpu_wr = wr; cpu_addr = a; cpu_din = d;
        step();
        cpu_ce = 1'b0; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_din = 8'h00;
        step();
    endtask

    task automatic rd16();
        bus(1'b1, 1'b1, 1'b0, 16'h4016, 8'h00);
    endtask

    task automatic wr16(input logic [7:0] d);
        bus(1'b1, 1'b0, 1'b1, 16'h4016, d);
    endtask

    initial begin
        Reset_n  = 1'b0;
        cpu_ce   = 1'b0;
        cpu_addr = 16'h0000;
        cpu_rd   = 1'b0;
        cpu_wr   = 1'b0;
        cpu_din  = 8'h00;
        keycode  = 8'h0E;
        model_reset();
        #12;
        check("reset_buttons", buttons, 8'h00);
        check("reset_dout", cpu_dout, 8'h00);
        check("reset_valid", {7'b0, cpu_dout_valid}, 8'h00);
        Reset_n = 1'b1;

        // Edge 1 captures 8'h0E; buttons follow 16 edges later (edge 17).
        for (int i = 1; i <= 20; i++) begin
            step();
            check("deb_latency", buttons, (i >= 17) ? 8'h01 : 8'h00);
        end

        // Keycode bouncing faster than the debounce window never lands.
        keycode = 8'h00;
        idle(20);
        check("release", buttons, 8'h00);
        for (int t = 0; t < 6; t++) begin
            keycode = t[0] ? 8'h00 : 8'h07;
            repeat (10) begin
                step();
                check("toggle_hold", buttons, 8'h00);
            end
        end

        // Right held: serial order A..Right, then 1s.
        keycode = 8'h07;
        idle(20);
        check("right", buttons, 8'h80);
        wr16(8'h01);
        wr16(8'h00);
        for (int i = 0; i < 10; i++) begin
            rd16();
            check("seq_bit0", {7'b0, cpu_dout[0]}, (i >= 7) ? 8'h01 : 8'h00);
            check("open_bus", {5'b0, cpu_dout[7:5]}, 8'h02);
        end

        // Strobe held high: reads repeat A without shifting.
        keycode = 8'h0E;
        idle(20);
        check("a_btn", buttons, 8'h01);
        wr16(8'h01);
        repeat (3) begin
            rd16();
            check("strobe_read", cpu_dout, 8'h41);
        end
        wr16(8'h00);
        rd16();
        check("first_a", cpu_dout, 8'h41);
        rd16();
        check("second_b", cpu_dout, 8'h40);
        bus(1'b1, 1'b1, 1'b0, 16'h4017, 8'h00);
        check("joy2_dout", cpu_dout, 8'h40);
        check("joy2_valid", {7'b0, cpu_dout_valid}, 8'h01);
        bus(1'b1, 1'b0, 1'b1, 16'h4017, 8'h01);
        rd16();
        check("joy2_wr_ignored", cpu_dout, 8'h40);
        bus(1'b0, 1'b0, 1'b1, 16'h4016, 8'h01);
        rd16();
        check("ce_low_ignored", cpu_dout, 8'h40);
        bus(1'b1, 1'b1, 1'b0, 16'h2002, 8'h00);
        check("other_rd_valid", {7'b0, cpu_dout_valid}, 8'h00);

        // Drive shift_reg to 8'hFE, then read and write $4016 together.
        wr16(8'h01);
        wr16(8'h00);
        repeat (7) rd16();
        bus(1'b1, 1'b1, 1'b1, 16'h4016, 8'h01);
        check("rdwr_dout", cpu_dout, 8'h40);
        rd16();
        check("rdwr_then_a", cpu_dout, 8'h41);
        rd16();
        check("rdwr_strobe_high", cpu_dout, 8'h41);

        // Asynchronous reset mid-sequence, away from any clock edge.
        wr16(8'h00);
        rd16();
        check("pre_reset_a", cpu_dout, 8'h41);
        #3;
        Reset_n = 1'b0;
        model_reset();
        #1;
        check("async_buttons", buttons, 8'h00);
        check("async_dout", cpu_dout, 8'h00);
        check("async_valid", {7'b0, cpu_dout_valid}, 8'h00);
        #2;
        Reset_n = 1'b1;
        rd16();
        check("post_reset_rd", cpu_dout, 8'h40);

        // Randomised traffic against the model.
        for (int n = 0; n < 400; n++) begin
            int unsigned op;
            logic [7:0]  d;
            if ($urandom_range(0, 7) == 0) keycode = key_pool[$urandom_range(0, 9)];
            op = $urandom_range(0, 6);
            d  = 8'($urandom);
            case (op)
                0: rd16();
                1: bus(1'b1, 1'b1, 1'b0, 16'h4017, 8'h00);
                2: wr16(d);
                3: bus(1'b1, 1'b1, 1'b1, 16'h4016, d);
                4: bus(1'b1, 1'b1, 1'b0, 16'h2000 + 16'($urandom_range(0, 7)), 8'h00);
                5: bus(1'b1, 1'b0, 1'b1, 16'h4017, d);
                default: bus(1'b0, 1'($urandom), 1'($urandom), 16'h4016, d);
            endcase
            idle($urandom_range(0, 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/nes_controller_port.md
Name: nes_controller_port

Overview:
- Player-1 NES controller responder.
- Consumes the USB HID keycode from the SoC keycode PIO, debounces it, and maps it to the 8 NES buttons.
- Presents the standard $4016/$4017 strobe/shift-register protocol to the NES CPU bus.
- Sits inside the NES architecture beside the CPU address decoder; player 2 is not connected.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive identical keycode samples required before the button vector updates.
- OPEN_BUS, 3'b010: value driven on cpu_dout[7:5] for controller reads (high byte of $40xx).

Ports:
- Clk  input  1  system clock, single domain.
- Reset_n  input  1  asynchronous active-low reset.
- cpu_ce  input  1  CPU cycle enable; cpu_rd and cpu_wr are honoured only when high.
- cpu_addr  input  16  CPU address bus.
- cpu_rd  input  1  CPU read request, one Clk wide when qualified.
- cpu_wr  input  1  CPU write request, one Clk wide when qualified.
- cpu_din  input  8  CPU write data.
- cpu_dout  output  8  read data for $4016/$4017.
- cpu_dout_valid  output  1  high while cpu_dout holds a controller read result.
- keycode  input  8  current USB keycode, 8'h00 = no key.
- buttons  output  8  debounced button vector {Right,Left,Down,Up,Start,Select,B,A}, for debug/LEDR.

Behaviour:
- Reset (async assert, sync release). All of the following clear to 0: buttons, shift_reg, strobe, cpu_dout, cpu_dout_valid, debounce counter, and the last-keycode register.
- Keymap (combinational from a candidate keycode):
  - 8'h0E→A(bit0), 8'h0D→B(bit1), 8'h2C→Select(bit2), 8'h28→Start(bit3).
  - 8'h1A→Up(bit4), 8'h16→Down(bit5), 8'h04→Left(bit6), 8'h07→Right(bit7).
  - Any other keycode → 8'h00.
- Debounce:
  - Each cycle compare keycode to last_kc.
  - If different: last_kc←keycode, cnt←0.
  - Else if cnt==DEBOUNCE_CYCLES-1: buttons←map(last_kc). cnt saturates and holds.
  - Else: cnt++.
  - Latency: buttons updates DEBOUNCE_CYCLES cycles after keycode becomes stable.
- Strobe write: cpu_ce & cpu_wr & cpu_addr==16'h4016 → strobe←cpu_din[0]. Writes to other addresses, including $4017 (APU frame counter), are ignored here.
- Reload: while strobe==1, shift_reg←buttons every cycle, so it tracks live buttons.
- Falling strobe: on the write cycle that clears strobe, shift_reg←buttons (final capture).
- Read $4016 (cpu_ce & cpu_rd):
  - cpu_dout←{OPEN_BUS,4'b0,shift_reg[0]} next cycle; cpu_dout_valid←1.
  - If strobe==0: shift_reg←{1'b1,shift_reg[7:1]}. After 8 reads, every further read returns bit0=1.
  - If strobe==1: no shift; a read returns the current A state.
- Read $4017: cpu_dout←{OPEN_BUS,5'b0}, valid←1, no shift.
- Read latency: registered, 1 Clk after the qualified cpu_rd. cpu_dout and valid hold until the next qualified read of any address. A read of any non-controller address clears valid to 0.
- Simultaneous read $4016 and write $4016 in the same cycle: the write takes effect. The read returns the pre-write shift_reg[0], and no shift occurs.
- cpu_rd/cpu_wr with cpu_ce==0 has no effect.
- Keycode changes mid-read-sequence do not alter shift_reg unless strobe==1.
- Reset mid-sequence: shift_reg=0, so the first read after reset with strobe 0 returns bit0=0.

Decomposition:
- Package nes_input_pkg holds:
  - key constants KC_A/KC_B/KC_SELECT/KC_START/KC_UP/KC_DOWN/KC_LEFT/KC_RIGHT;
  - button bit indices;
  - the address constants JOY1_ADDR=16'h4016 and JOY2_ADDR=16'h4017.
- One sub-module, keycode_debouncer: last_kc, cnt, and the buttons register, parameterised by DEBOUNCE_CYCLES.
- The keymap is a package function.

Test Plan:
- Reset with keycode=8'h0E held for 20 cycles → buttons=8'h01 at exactly cycle 16 after stable, and 8'h00 before that.
- keycode toggles 8'h07/8'h00 every 10 cycles → buttons stays 8'h00 and never updates.
- buttons=8'h80 (Right); write $4016=1 then 0; 10 reads of $4016 → bit0 sequence 0,0,0,0,0,0,0,1,1,1 and cpu_dout[7:5]=3'b010 on each read.
- strobe=1 with buttons=8'h01; 3 reads → each returns 8'h41; shift_reg is unchanged.
- Read $4017 → cpu_dout=8'h40, valid=1; a write to $4017 with din=8'h01 leaves strobe=0.
- Same-cycle read+write of $4016 (din=1) with shift_reg=8'hFE → dout bit0=0, strobe=1, and the next read returns buttons[0]. Assert Reset_n low mid-sequence → all outputs 0 immediately, without waiting for a Clk edge.
